// File: rtl/pll_seq_pkg.sv
// Shared types and width helpers for the PLL reset/lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  // Counter must be able to reach the largest of the three cycle limits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  // Attempt index width; never narrower than one bit, even with no retries.
  function automatic int retry_width(input int max_retries);
    int w;
    w = $clog2(max_retries + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module cdc_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain; clears to 0 on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], din};
  end

  assign dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the clock wizard: pulses pll_reset, waits for a
// qualified lock, then releases the downstream reset. Runs on the board clock.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  RESET_PLL | pll_reset held high for RST_HOLD_CYCLES
//  WAIT_LOCK | pll_reset low, waiting up to LOCK_TIMEOUT for lk
//  STABLE    | lk seen, must hold for LOCK_STABLE cycles; drop = glitch
//  RUN       | lock qualified, user reset released, pll_ready high
//  FAIL      | all attempts timed out; wizard kept in reset until restart
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 20,
  parameter int LOCK_TIMEOUT    = 200000,
  parameter int LOCK_STABLE     = 1024,
  parameter int MAX_RETRIES     = 3,
  parameter int SYNC_STAGES     = 2,
  localparam int RW = retry_width(MAX_RETRIES)
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          pll_locked,
  input  logic          soft_restart,
  output logic          pll_reset,
  output logic          user_rst_n,
  output logic          pll_ready,
  output logic          pll_fail,
  output logic          lock_lost,
  output logic [RW-1:0] retry_cnt
);

  localparam int CW = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

  state_t          state, nxt_state;
  logic [CW-1:0]   cnt;
  logic            cnt_clr;
  logic [RW-1:0]   nxt_retry;
  logic            nxt_lost;
  logic            nxt_pll_reset, nxt_user_rst_n, nxt_ready, nxt_fail;
  logic            lk;

  cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk  (sys_clk),
    .rst_n(rst_n),
    .din  (pll_locked),
    .dout (lk)
  );

  // State, counter, attempt index and registered outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESET_PLL;
      cnt        <= '0;
      retry_cnt  <= '0;
      pll_reset  <= 1'b1;
      user_rst_n <= 1'b0;
      pll_ready  <= 1'b0;
      pll_fail   <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= cnt_clr ? '0 : cnt + CW'(1);
      retry_cnt  <= nxt_retry;
      pll_reset  <= nxt_pll_reset;
      user_rst_n <= nxt_user_rst_n;
      pll_ready  <= nxt_ready;
      pll_fail   <= nxt_fail;
      lock_lost  <= nxt_lost;
    end
  end

  // Next-state logic; soft_restart overrides everything the state logic decides.
  always_comb begin
    nxt_state = state;
    nxt_retry = retry_cnt;
    nxt_lost  = 1'b0;
    case (state)
      RESET_PLL: if (cnt == CW'(RST_HOLD_CYCLES - 1)) nxt_state = WAIT_LOCK;
      WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (lk) nxt_state = STABLE;
        else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          if (retry_cnt == RW'(MAX_RETRIES)) nxt_state = FAIL;
          else begin
            nxt_retry = retry_cnt + RW'(1);
            nxt_state = RESET_PLL;
          end
        end
      end
      STABLE: begin
        if (!lk) nxt_state = WAIT_LOCK;
        else if (cnt == CW'(LOCK_STABLE - 1)) nxt_state = RUN;
      end
      RUN: begin
        if (!lk) begin
          nxt_state = RESET_PLL;
          nxt_retry = '0;
          nxt_lost  = 1'b1;
        end
      end
      FAIL:    nxt_state = FAIL;
      default: nxt_state = RESET_PLL;
    endcase
    if (soft_restart) begin
      nxt_state = RESET_PLL;
      nxt_retry = '0;
      nxt_lost  = 1'b0;
    end
    // A restart inside RESET_PLL must also restart the hold count.
    cnt_clr = (nxt_state != state) || soft_restart;
  end

  // Output decode from the next state so outputs change on the transition edge.
  always_comb begin
    nxt_pll_reset  = (nxt_state == RESET_PLL) || (nxt_state == FAIL);
    nxt_user_rst_n = (nxt_state == RUN);
    nxt_ready      = (nxt_state == RUN);
    nxt_fail       = (nxt_state == FAIL);
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short cycle limits.
module tb_pll_lock_sequencer;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_restart = 1'b0;
  logic       pll_reset, user_rst_n, pll_ready, pll_fail, lock_lost;
  logic [1:0] retry_cnt;
  logic [6:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES(4),
    .LOCK_TIMEOUT   (16),
    .LOCK_STABLE    (8),
    .MAX_RETRIES    (2),
    .SYNC_STAGES    (2)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .soft_restart(soft_restart),
    .pll_reset   (pll_reset),
    .user_rst_n  (user_rst_n),
    .pll_ready   (pll_ready),
    .pll_fail    (pll_fail),
    .lock_lost   (lock_lost),
    .retry_cnt   (retry_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // {pll_reset, user_rst_n, pll_ready, pll_fail, lock_lost, retry_cnt}
  assign outs = {pll_reset, user_rst_n, pll_ready, pll_fail, lock_lost, retry_cnt};

  typedef struct {
    int         n;
    logic       locked;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [6:0] exp);
    n_tests++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (rst,urst_n,rdy,fail,lost,retry)", name, outs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Leaves time 4 units after a posedge with rst_n released; next edge is e1.
  task automatic do_reset();
    rst_n = 1'b0;
    pll_locked = 1'b0;
    soft_restart = 1'b0;
    step(3);
    chk("reset_values", 7'b1000000);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1,  1'b0, 7'b1000000};
    tbl[1]  = '{2,  1'b0, 7'b1000000};
    tbl[2]  = '{1,  1'b0, 7'b0000000};
    tbl[3]  = '{6,  1'b0, 7'b0000000};
    tbl[4]  = '{10, 1'b1, 7'b0000000};
    tbl[5]  = '{1,  1'b1, 7'b0110000};
    tbl[6]  = '{5,  1'b1, 7'b0110000};
    tbl[7]  = '{2,  1'b0, 7'b0110000};
    tbl[8]  = '{1,  1'b0, 7'b1000100};
    tbl[9]  = '{1,  1'b0, 7'b1000000};
    tbl[10] = '{2,  1'b0, 7'b1000000};
    tbl[11] = '{1,  1'b0, 7'b0000000};
    tbl[12] = '{10, 1'b1, 7'b0000000};
    tbl[13] = '{1,  1'b1, 7'b0110000};

    // Lock after 10 cycles, run, lose lock, relock.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      pll_locked = tbl[i].locked;
      step(tbl[i].n);
      chk($sformatf("table_%0d", i), tbl[i].exp);
    end

    // No lock: three timed-out attempts, then FAIL.
    do_reset();
    step(19); chk("to_e19", 7'b0000000);
    step(1);  chk("to_retry1", 7'b1000001);
    step(4);  chk("to_wait2", 7'b0000001);
    step(16); chk("to_retry2", 7'b1000010);
    step(19); chk("to_e59", 7'b0000010);
    step(1);  chk("to_fail", 7'b1001010);
    step(20); chk("fail_held", 7'b1001010);

    // soft_restart out of FAIL, then full sequence with lock present.
    soft_restart = 1'b1;
    step(1);  chk("soft_fail_exit", 7'b1000000);
    soft_restart = 1'b0;
    pll_locked = 1'b1;
    step(3);  chk("soft_hold", 7'b1000000);
    step(1);  chk("soft_wait", 7'b0000000);
    step(8);  chk("soft_stable", 7'b0000000);
    step(1);  chk("soft_run", 7'b0110000);

    // Asynchronous reset between clock edges while in RUN.
    step(2);  chk("pre_async_run", 7'b0110000);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", 7'b1000000);

    // soft_restart inside RESET_PLL restarts the hold count.
    do_reset();
    step(2);
    soft_restart = 1'b1;
    step(1);  chk("soft_in_reset", 7'b1000000);
    soft_restart = 1'b0;
    step(3);  chk("soft_rehold", 7'b1000000);
    step(1);  chk("soft_rehold_end", 7'b0000000);

    // Lock glitch while in STABLE.
    do_reset();
    step(10);
    pll_locked = 1'b1;
    step(6);  chk("glitch_stable", 7'b0000000);
    pll_locked = 1'b0;
    step(3);  chk("glitch_wait", 7'b0000000);
    pll_locked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk($sformatf("glitch_hold_%0d", i), 7'b0000000);
    end
    step(1);  chk("glitch_run", 7'b0110000);

    // Lock arrives on the same cycle WAIT_LOCK times out.
    do_reset();
    step(17);
    pll_locked = 1'b1;
    step(3);  chk("simul_to_lock", 7'b0000000);
    step(7);  chk("simul_stable", 7'b0000000);
    step(1);  chk("simul_run", 7'b0110000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
